// File: rtl/gmsk_burst_sequencer.sv
// -----------------------------------------------------------------------------
// gmsk_burst_sequencer
//   Burst controller between a symbol source and a GMSK modulator / RF chain.
//   After reset it feeds PRIME_SYMBOLS idle symbols ('1') to prime the
//   modulator, then arms. On fire_burst it streams BURST_SYMBOLS payload
//   symbols from a valid/ready source and appends GUARD_SYMBOLS idle tail
//   symbols. Modulator I/Q are gated onto the RF chain with iq_valid, aligned
//   to the payload symbols through a fixed modulator latency. A free-running
//   sample_strobe is also generated.
//
// Ports
//   clock, reset          system clock, synchronous active-high reset
//   symbol_input_strobe   rising edge: modulator latches current_symbol
//   symbol_iq_strobe      rising edge: first I/Q sample of the next symbol
//   sample_strobe         1-cycle pulse every CLOCKS_PER_SAMPLE clocks
//   fire_burst            burst start request, honoured only while is_armed
//   is_armed              ready to accept fire_burst
//   burst_active          high from accepted fire until burst_done
//   burst_done            1-cycle pulse when the last guard symbol is consumed
//   underrun              sticky: a payload slot found sym_valid low
//   sym_data, sym_valid   payload symbol source
//   sym_ready             combinational: sym_data consumed this cycle
//   current_symbol        symbol presented to the modulator
//   modulator_inphase/quadrature   modulator I/Q
//   rfchain_inphase/quadrature     gated I/Q to the RF chain
//   iq_valid              rfchain_* carry burst samples
// -----------------------------------------------------------------------------
module gmsk_burst_sequencer #(
   parameter int IQ_WIDTH            = 8,
   parameter int CLOCKS_PER_SAMPLE   = 5,
   parameter int PRIME_SYMBOLS       = 4,
   parameter int BURST_SYMBOLS       = 148,
   parameter int GUARD_SYMBOLS       = 8,
   parameter int MOD_LATENCY_SYMBOLS = 3
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       symbol_input_strobe,
   input  logic                       symbol_iq_strobe,
   output logic                       sample_strobe,
   input  logic                       fire_burst,
   output logic                       is_armed,
   output logic                       burst_active,
   output logic                       burst_done,
   output logic                       underrun,
   input  logic                       sym_data,
   input  logic                       sym_valid,
   output logic                       sym_ready,
   output logic                       current_symbol,
   input  logic signed [IQ_WIDTH-1:0] modulator_inphase,
   input  logic signed [IQ_WIDTH-1:0] modulator_quadrature,
   output logic signed [IQ_WIDTH-1:0] rfchain_inphase,
   output logic signed [IQ_WIDTH-1:0] rfchain_quadrature,
   output logic                       iq_valid
);

   localparam int SW = $clog2(CLOCKS_PER_SAMPLE + 1);
   localparam int PW = $clog2(PRIME_SYMBOLS + 1);
   localparam int BW = $clog2(BURST_SYMBOLS + 1);
   localparam int GW = (GUARD_SYMBOLS > 0) ? $clog2(GUARD_SYMBOLS + 1) : 1;
   localparam int CW = $clog2(MOD_LATENCY_SYMBOLS + BURST_SYMBOLS + 1);

   localparam logic [SW-1:0] SAMPLE_LAST = SW'(CLOCKS_PER_SAMPLE - 1);
   localparam logic [PW-1:0] PRIME_LAST  = PW'(PRIME_SYMBOLS - 1);
   localparam logic [BW-1:0] BURST_LAST  = BW'(BURST_SYMBOLS - 1);
   localparam logic [GW-1:0] GUARD_LAST  = GW'((GUARD_SYMBOLS > 0) ? GUARD_SYMBOLS - 1 : 0);
   localparam logic [CW-1:0] GATE_OPEN   = CW'(MOD_LATENCY_SYMBOLS);
   localparam logic [CW-1:0] GATE_CLOSE  = CW'(MOD_LATENCY_SYMBOLS + BURST_SYMBOLS);

   typedef enum logic [1:0] {PRIME, ARMED, PAYLOAD, TAIL} state_t;

   state_t        state;
   logic [PW-1:0] prime_cnt;
   logic [BW-1:0] slot_cnt;
   logic [GW-1:0] guard_cnt;
   logic [SW-1:0] sample_cnt;
   logic          in_prev;
   logic          iq_prev;

   logic          gate_busy;
   logic          gate_en;
   logic [CW-1:0] gate_cnt;

   logic                       stage1_valid;
   logic signed [IQ_WIDTH-1:0] stage1_inphase;
   logic signed [IQ_WIDTH-1:0] stage1_quadrature;

   logic          in_edge;
   logic          iq_edge;
   logic          gate_start;
   logic          gate_track;
   logic          gate_step;
   logic [CW-1:0] gate_cnt_nxt;
   logic          gate_open_evt;
   logic          gate_close_evt;
   logic          gate_en_nxt;
   logic          gate_busy_nxt;

   // Edge detection and I/Q gate next-state. The gate tracks iq-strobe edges
   // from the first payload input edge (an iq edge in that same cycle counts)
   // and stays busy until it closes, independently of the burst FSM.
   // NOTE: every signal driven here gets a value on every path, so no latch
   // can be inferred.
   always_comb begin
      in_edge        = symbol_input_strobe & ~in_prev;
      iq_edge        = symbol_iq_strobe & ~iq_prev;
      gate_start     = (state == PAYLOAD) && in_edge && (slot_cnt == '0);
      gate_track     = gate_busy | gate_start;
      gate_step      = gate_track & iq_edge;
      gate_cnt_nxt   = (gate_start ? '0 : gate_cnt) + CW'(gate_step);
      gate_open_evt  = gate_step && (gate_cnt_nxt == GATE_OPEN);
      gate_close_evt = gate_step && (gate_cnt_nxt == GATE_CLOSE);
      gate_en_nxt    = gate_open_evt | (gate_en & ~gate_close_evt);
      gate_busy_nxt  = gate_track & ~gate_close_evt;
      // Ready is a same-cycle handshake with the consuming input edge.
      sym_ready      = !reset && (state == PAYLOAD) && in_edge && sym_valid;
   end

   // Strobe history resets to 1 so a strobe held high through reset is not
   // seen as an edge.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clock) begin
      if (reset) begin
         in_prev <= 1'b1;
         iq_prev <= 1'b1;
      end else begin
         in_prev <= symbol_input_strobe;
         iq_prev <= symbol_iq_strobe;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sample_cnt    <= '0;
         sample_strobe <= 1'b0;
      end else if (sample_cnt == SAMPLE_LAST) begin
         sample_cnt    <= '0;
         sample_strobe <= 1'b1;
      end else begin
         sample_cnt    <= sample_cnt + SW'(1);
         sample_strobe <= 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         gate_busy <= 1'b0;
         gate_en   <= 1'b0;
         gate_cnt  <= '0;
      end else begin
         gate_busy <= gate_busy_nxt;
         gate_en   <= gate_en_nxt;
         gate_cnt  <= gate_cnt_nxt;
      end
   end

   // Two register stages: the sample present on the opening-edge cycle is the
   // first one forwarded, the sample on the closing-edge cycle is dropped.
   always_ff @(posedge clock) begin
      if (reset) begin
         stage1_valid       <= 1'b0;
         stage1_inphase     <= '0;
         stage1_quadrature  <= '0;
         iq_valid           <= 1'b0;
         rfchain_inphase    <= '0;
         rfchain_quadrature <= '0;
      end else begin
         stage1_valid       <= gate_en_nxt;
         stage1_inphase     <= gate_en_nxt ? modulator_inphase : '0;
         stage1_quadrature  <= gate_en_nxt ? modulator_quadrature : '0;
         iq_valid           <= stage1_valid;
         rfchain_inphase    <= stage1_inphase;
         rfchain_quadrature <= stage1_quadrature;
      end
   end

   // Burst FSM. A return to ARMED keeps is_armed low while the I/Q gate of
   // the previous burst is still busy, so a new fire cannot overlap it.
   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= PRIME;
         current_symbol <= 1'b1;
         is_armed       <= 1'b0;
         burst_active   <= 1'b0;
         burst_done     <= 1'b0;
         underrun       <= 1'b0;
         prime_cnt      <= '0;
         slot_cnt       <= '0;
         guard_cnt      <= '0;
      end else begin
         burst_done <= 1'b0;
         unique case (state)
            PRIME: begin
               if (in_edge) begin
                  if (prime_cnt == PRIME_LAST) begin
                     state    <= ARMED;
                     is_armed <= ~gate_busy_nxt;
                  end else begin
                     prime_cnt <= prime_cnt + PW'(1);
                  end
               end
            end
            ARMED: begin
               // An input edge coincident with fire still latches idle.
               if (in_edge) current_symbol <= 1'b1;
               if (fire_burst && is_armed) begin
                  state        <= PAYLOAD;
                  is_armed     <= 1'b0;
                  burst_active <= 1'b1;
                  underrun     <= 1'b0;
                  slot_cnt     <= '0;
               end else begin
                  is_armed <= ~gate_busy_nxt;
               end
            end
            PAYLOAD: begin
               if (in_edge) begin
                  if (sym_valid) begin
                     current_symbol <= sym_data;
                  end else begin
                     current_symbol <= 1'b1;
                     underrun       <= 1'b1;
                  end
                  if (slot_cnt == BURST_LAST) begin
                     guard_cnt <= '0;
                     if (GUARD_SYMBOLS == 0) begin
                        burst_done   <= 1'b1;
                        burst_active <= 1'b0;
                        state        <= ARMED;
                        is_armed     <= ~gate_busy_nxt;
                     end else begin
                        state <= TAIL;
                     end
                  end else begin
                     slot_cnt <= slot_cnt + BW'(1);
                  end
               end
            end
            TAIL: begin
               if (in_edge) begin
                  current_symbol <= 1'b1;
                  if (guard_cnt == GUARD_LAST) begin
                     burst_done   <= 1'b1;
                     burst_active <= 1'b0;
                     state        <= ARMED;
                     is_armed     <= ~gate_busy_nxt;
                  end else begin
                     guard_cnt <= guard_cnt + GW'(1);
                  end
               end
            end
            default: state <= PRIME;
         endcase
      end
   end

endmodule

// File: tb/tb_gmsk_burst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gmsk_burst_sequencer
//   Directed bench for gmsk_burst_sequencer with default parameters. Strobes
//   are free-running (input edge every 10 clocks, iq edge offset by 5). A
//   behavioural model, written in terms of "edges since reset" and "slots
//   since fire", predicts every output on every cycle; a few literal checks
//   pin the model to hand-derived numbers.
// -----------------------------------------------------------------------------
module tb_gmsk_burst_sequencer;

   localparam int IQW    = 8;
   localparam int CPS    = 5;
   localparam int PRIME  = 4;
   localparam int BURST  = 148;
   localparam int GUARD  = 8;
   localparam int MODLAT = 3;

   logic clock = 1'b0;
   logic reset, in_s, iq_s, fire, valid, data;
   logic signed [IQW-1:0] mod_i, mod_q, rf_i, rf_q;
   logic ss, armed, active, done, under, ready, cur, iqv;

   always #5 clock = ~clock;

   gmsk_burst_sequencer #(
      .IQ_WIDTH(IQW), .CLOCKS_PER_SAMPLE(CPS), .PRIME_SYMBOLS(PRIME),
      .BURST_SYMBOLS(BURST), .GUARD_SYMBOLS(GUARD), .MOD_LATENCY_SYMBOLS(MODLAT)
   ) dut (
      .clock(clock), .reset(reset),
      .symbol_input_strobe(in_s), .symbol_iq_strobe(iq_s),
      .sample_strobe(ss), .fire_burst(fire), .is_armed(armed),
      .burst_active(active), .burst_done(done), .underrun(under),
      .sym_data(data), .sym_valid(valid), .sym_ready(ready),
      .current_symbol(cur),
      .modulator_inphase(mod_i), .modulator_quadrature(mod_q),
      .rfchain_inphase(rf_i), .rfchain_quadrature(rf_q), .iq_valid(iqv)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- stimulus driver: strobes, modulator, symbol source ----
   int   cyc    = 0;
   int   tx_idx = 0;
   logic hs;

   initial begin
      in_s  = 1'b0;
      iq_s  = 1'b0;
      data  = 1'b1;
      mod_i = '0;
      mod_q = '0;
      forever begin
         @(negedge clock);
         hs = ready;
         @(posedge clock);
         #1;
         if (hs === 1'b1) tx_idx++;
         cyc++;
         in_s  = (cyc % 10) < 3;
         iq_s  = ((cyc + 5) % 10) < 3;
         data  = (tx_idx % 2) == 0;
         mod_i = IQW'(cyc);
         mod_q = IQW'(cyc * 3 + 7);
      end
   end

   // ---------------- behavioural model + per-cycle compare ----------------
   logic m_known = 1'b0;
   logic m_prev_in, m_prev_iq;
   int   m_primed, m_slot, m_iqcnt, m_ss_cnt, m_edges;
   logic m_track;
   logic e_cur, e_armed, e_active, e_done, e_under, e_ss, e_v, s1_v;
   logic signed [IQW-1:0] e_i, e_q, s1_i, s1_q;
   logic ein, eiq, gated, e_ready;
   int   mon_ready = 0, mon_done = 0, mon_iqv = 0, mon_ss = 0;

   always @(negedge clock) begin
      ein = in_s && !m_prev_in;
      eiq = iq_s && !m_prev_iq;
      if (m_known) begin
         e_ready = !reset && (m_slot >= 0) && (m_slot < BURST) && ein && valid;
         check("current_symbol", cur, e_cur);
         check("is_armed", armed, e_armed);
         check("burst_active", active, e_active);
         check("burst_done", done, e_done);
         check("underrun", under, e_under);
         check("sample_strobe", ss, e_ss);
         check("sym_ready", ready, e_ready);
         check("iq_valid", iqv, e_v);
         check("rfchain_inphase", rf_i, e_i);
         check("rfchain_quadrature", rf_q, e_q);
         if (ready === 1'b1) mon_ready++;
         if (done === 1'b1) mon_done++;
         if (iqv === 1'b1) mon_iqv++;
         if (ss === 1'b1) mon_ss++;
      end
      if (reset) begin
         m_prev_in = 1'b1; m_prev_iq = 1'b1;
         m_primed = 0; m_slot = -1; m_track = 1'b0; m_iqcnt = 0;
         m_ss_cnt = 0; m_edges = 0;
         e_cur = 1'b1; e_armed = 1'b0; e_active = 1'b0; e_done = 1'b0;
         e_under = 1'b0; e_ss = 1'b0; e_v = 1'b0; e_i = '0; e_q = '0;
         s1_v = 1'b0; s1_i = '0; s1_q = '0;
         m_known = 1'b1;
      end else begin
         m_prev_in = in_s;
         m_prev_iq = iq_s;
         if (ein) m_edges++;
         m_ss_cnt++;
         e_ss   = (m_ss_cnt % CPS) == 0;
         e_done = 1'b0;
         if (m_slot < 0) begin
            if (m_primed < PRIME) begin
               if (ein) m_primed++;
            end else begin
               if (ein) e_cur = 1'b1;
               if (fire && e_armed) begin
                  m_slot = 0; e_active = 1'b1; e_under = 1'b0;
               end
            end
         end else if (ein) begin
            if (m_slot < BURST) begin
               if (m_slot == 0) begin m_track = 1'b1; m_iqcnt = 0; end
               if (valid) e_cur = data;
               else begin e_cur = 1'b1; e_under = 1'b1; end
            end else begin
               e_cur = 1'b1;
            end
            m_slot++;
            if (m_slot == BURST + GUARD) begin
               e_done = 1'b1; e_active = 1'b0; m_slot = -1;
            end
         end
         gated = 1'b0;
         if (m_track) begin
            if (eiq) m_iqcnt++;
            gated = (m_iqcnt >= MODLAT) && (m_iqcnt < MODLAT + BURST);
            if (m_iqcnt >= MODLAT + BURST) m_track = 1'b0;
         end
         e_v = s1_v; e_i = s1_i; e_q = s1_q;
         s1_v = gated;
         s1_i = gated ? mod_i : '0;
         s1_q = gated ? mod_q : '0;
         e_armed = (m_primed >= PRIME) && (m_slot < 0) && !m_track;
      end
   end

   // ---------------- sequencing helpers ----------------
   task automatic step();
      @(posedge clock);
      #2;
   endtask

   task automatic wait_armed(input int limit, input string name);
      int k = 0;
      while (armed !== 1'b1 && k < limit) begin step(); k++; end
      check(name, armed, 1'b1);
   endtask

   task automatic wait_done(input int limit, input string name);
      int k = 0;
      while (done !== 1'b1 && k < limit) begin step(); k++; end
      check(name, done, 1'b1);
   endtask

   task automatic wait_tx(input int target, input int limit, input string name);
      int k = 0;
      while (tx_idx < target && k < limit) begin step(); k++; end
      check(name, tx_idx >= target, 1'b1);
   endtask

   task automatic wait_phase(input int p);
      int k = 0;
      while ((cyc % 10) != p && k < 20) begin step(); k++; end
   endtask

   // ---------------- directed scenario ----------------
   int base_ready, base_done, base_iqv, base_tx, base_ss;

   initial begin
      reset = 1'b1;
      fire  = 1'b0;
      valid = 1'b0;
      repeat (3) step();
      reset = 1'b0;

      // Priming: a fire during PRIME is ignored; arming follows the 4th edge.
      repeat (5) step();
      fire = 1'b1; step(); fire = 1'b0;
      wait_armed(200, "arm_after_prime");
      check("prime_edges", m_edges, 4);
      check("armed_idle_symbol", cur, 1'b1);

      // Full burst with continuous data.
      valid = 1'b1;
      wait_phase(5);
      base_ready = mon_ready; base_done = mon_done; base_iqv = mon_iqv;
      fire = 1'b1; step(); fire = 1'b0;
      wait_done(2500, "burst1_done");
      check("burst1_rearm", armed, 1'b1);
      step();
      check("burst1_ready_pulses", mon_ready - base_ready, 148);
      check("burst1_done_pulses", mon_done - base_done, 1);
      check("burst1_iq_valid_cycles", mon_iqv - base_iqv, 1480);
      check("burst1_tail_symbol", cur, 1'b1);

      // Underrun at payload slot 50.
      wait_phase(5);
      base_ready = mon_ready; base_tx = tx_idx;
      fire = 1'b1; step(); fire = 1'b0;
      wait_tx(base_tx + 50, 1000, "burst2_slot50_reached");
      valid = 1'b0;
      repeat (10) step();
      valid = 1'b1;
      check("burst2_underrun_set", under, 1'b1);
      wait_done(2500, "burst2_done");
      step();
      check("burst2_ready_pulses", mon_ready - base_ready, 147);
      check("burst2_underrun_sticky", under, 1'b1);

      // Fire coincident with an input edge; that edge is not payload.
      wait_phase(0);
      base_tx = tx_idx;
      fire = 1'b1; step(); fire = 1'b0;
      check("burst3_underrun_cleared", under, 1'b0);
      check("burst3_active", active, 1'b1);
      repeat (5) step();
      check("coincident_edge_not_consumed", tx_idx - base_tx, 0);
      repeat (10) step();
      check("first_payload_next_edge", tx_idx - base_tx, 1);
      fire = 1'b1; step(); fire = 1'b0;   // ignored during PAYLOAD

      // Reset at payload slot 70.
      wait_tx(base_tx + 70, 1000, "burst3_slot70_reached");
      reset = 1'b1;
      step();
      check("reset_active", active, 1'b0);
      check("reset_armed", armed, 1'b0);
      check("reset_symbol", cur, 1'b1);
      check("reset_iq_valid", iqv, 1'b0);
      reset = 1'b0;
      wait_armed(200, "rearm_after_reset");
      check("reprime_edges", m_edges, 4);

      // sample_strobe cadence.
      base_ss = mon_ss;
      repeat (50) step();
      check("sample_strobe_count", mon_ss - base_ss, 10);

      repeat (3) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
